// File: rtl/countdown_controller.sv
// countdown_controller: sequences the one-second Timer into a user countdown.
// Loads a seconds value, runs the Timer, consumes each secondMarker, clears
// the Timer after every marker and raises an alarm at zero.
// Optional feature macro: AUTO_RELOAD_EN (restart from the loaded value on expiry).
module countdown_controller #(
   parameter int unsigned SEC_WIDTH = 12
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 startPress,
   input  logic                 pausePress,
   input  logic                 clearPress,
   input  logic [SEC_WIDTH-1:0] loadValue,
   input  logic                 secondMarker,
   output logic                 timerEnable,
   output logic                 timerReset,
   output logic [SEC_WIDTH-1:0] secondsLeft,
   output logic                 running,
   output logic                 alarm
);

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      RECLR,
      PAUSE,
      DONE
   } state_t;

   state_t               state;
   state_t               nextState;
   logic [SEC_WIDTH-1:0] nextSeconds;
   logic                 markerHeld;
   logic                 markerTake;
   logic                 expirePulse;
   logic                 nextEnable;
   logic                 nextTimerReset;
   logic                 nextRunning;
   logic                 nextAlarm;
`ifdef AUTO_RELOAD_EN
   logic [SEC_WIDTH-1:0] reloadValue;
   logic [SEC_WIDTH-1:0] nextReload;
`endif

   // Next-state, next-count and registered-output decode; clearPress wins over all.
   always_comb begin
      nextState   = state;
      nextSeconds = secondsLeft;
      markerTake  = 1'b0;
      expirePulse = 1'b0;
`ifdef AUTO_RELOAD_EN
      nextReload  = reloadValue;
`endif
      if (clearPress) begin
         nextState   = IDLE;
         nextSeconds = '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (startPress && (loadValue != '0)) begin
                  nextState   = RUN;
                  nextSeconds = loadValue;
`ifdef AUTO_RELOAD_EN
                  nextReload  = loadValue;
`endif
               end
            end
            RUN: begin
               // A marker still high from an already-consumed second is not
               // counted again, so a held marker yields one decrement.
               if (secondMarker && !markerHeld) begin
                  markerTake = 1'b1;
                  if (secondsLeft > SEC_WIDTH'(1)) begin
                     nextState   = RECLR;
                     nextSeconds = secondsLeft - SEC_WIDTH'(1);
                  end else begin
`ifdef AUTO_RELOAD_EN
                     nextState   = RECLR;
                     nextSeconds = reloadValue;
                     expirePulse = 1'b1;
`else
                     nextState   = DONE;
                     nextSeconds = '0;
`endif
                  end
               end else if (pausePress) begin
                  nextState = PAUSE;
               end
            end
            RECLR: begin
               nextState = pausePress ? PAUSE : RUN;
            end
            PAUSE: begin
               if (startPress) nextState = RUN;
            end
            DONE: begin
               if (startPress) nextState = IDLE;
            end
            default: begin
               nextState   = IDLE;
               nextSeconds = '0;
            end
         endcase
      end
      nextEnable     = (nextState == RUN);
      nextTimerReset = (nextState == IDLE) || (nextState == RECLR) || (nextState == DONE);
      nextRunning    = (nextState == RUN) || (nextState == RECLR);
      nextAlarm      = (nextState == DONE) || expirePulse;
   end

   // State, count and outputs all update together on the clock edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         secondsLeft <= '0;
         timerEnable <= 1'b0;
         timerReset  <= 1'b1;
         running     <= 1'b0;
         alarm       <= 1'b0;
         markerHeld  <= 1'b0;
      end else begin
         state       <= nextState;
         secondsLeft <= nextSeconds;
         timerEnable <= nextEnable;
         timerReset  <= nextTimerReset;
         running     <= nextRunning;
         alarm       <= nextAlarm;
         markerHeld  <= secondMarker && (markerHeld || markerTake);
      end
   end

`ifdef AUTO_RELOAD_EN
   // Reload register holds the value captured when starting from IDLE.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) reloadValue <= '0;
      else        reloadValue <= nextReload;
   end
`endif

endmodule
